// File: rtl/sar_sample_timer_if.sv
// Control/status bundle between the SAR sample timer and its consumers.
// The master side programs the period/window/channels; the slave side returns the strobes.
interface sar_sample_timer_if #(
  parameter int CNT_W = 8,
  parameter int N_CH  = 4,
  parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
);

  logic             enable;
  logic [CNT_W-1:0] div_ratio;
  logic [CNT_W-1:0] acq_len;
  logic [N_CH-1:0]  ch_mask;

  logic             sample_pulse;
  logic             acq;
  logic             conv_start;
  logic [CH_W-1:0]  ch_sel;
  logic             busy;

  modport master (
    output enable,
    output div_ratio,
    output acq_len,
    output ch_mask,
    input  sample_pulse,
    input  acq,
    input  conv_start,
    input  ch_sel,
    input  busy
  );

  modport slave (
    input  enable,
    input  div_ratio,
    input  acq_len,
    input  ch_mask,
    output sample_pulse,
    output acq,
    output conv_start,
    output ch_sel,
    output busy
  );

endinterface

// File: rtl/sar_sample_timer.sv
// Programmable sample/convert sequencer: period, acquisition window, convert strobe and
// round-robin channel selection, all as registered clock enables in the clk_in domain.
module sar_sample_timer #(
  parameter int CNT_W = 8,
  parameter int N_CH  = 4
) (
  input  logic                clk_in,
  input  logic                rst_n,
  sar_sample_timer_if.slave   bus
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    CONV = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] periodEff_q, periodEff_d;
  logic [CNT_W-1:0] acqEff_q, acqEff_d;
  logic [CH_W-1:0]  chSel_q, chSel_d;
  logic             samplePulse_q, samplePulse_d;
  logic             acq_q, acq_d;
  logic             convStart_q, convStart_d;
  logic             busy_q, busy_d;

  logic [CNT_W-1:0] periodIn;
  logic [CNT_W-1:0] acqFloor;
  logic [CNT_W-1:0] acqIn;
  logic [CH_W-1:0]  nextCh;
  logic [CH_W-1:0]  candIdx;
  int               cand;
  logic             startCond;
  logic             periodEnd;
  logic             startNow;

  // Clamp the live programming inputs; they only matter at a period start.
  always_comb begin
    periodIn = (bus.div_ratio < CNT_W'(2)) ? CNT_W'(2) : bus.div_ratio;
    acqFloor = (bus.acq_len == '0) ? CNT_W'(1) : bus.acq_len;
    acqIn    = (acqFloor > (periodIn - CNT_W'(1))) ? (periodIn - CNT_W'(1)) : acqFloor;
  end

  // Round-robin search: scanning distances from N_CH down to 1 lets the nearest hit win,
  // and distance N_CH is the current channel itself, so it is only chosen as a last resort.
  always_comb begin
    nextCh  = chSel_q;
    cand    = 0;
    candIdx = '0;
    for (int k = N_CH; k >= 1; k--) begin
      cand = int'(chSel_q) + k;
      if (cand >= N_CH) begin
        cand = cand - N_CH;
      end
      candIdx = CH_W'(cand);
      if (bus.ch_mask[candIdx]) begin
        nextCh = candIdx;
      end
    end
  end

  always_comb begin
    startCond = bus.enable && (bus.ch_mask != '0);
    periodEnd = (state_q == CONV) && (cnt_q == (periodEff_q - CNT_W'(1)));
    startNow  = startCond && ((state_q == IDLE) || periodEnd);
  end

  // Next-state logic; the shadow period/window are only reloaded at a period start so that
  // mid-period reprogramming cannot disturb the period in flight.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    periodEff_d = periodEff_q;
    acqEff_d    = acqEff_q;
    chSel_d     = chSel_q;

    if (startNow) begin
      state_d     = ACQ;
      cnt_d       = '0;
      periodEff_d = periodIn;
      acqEff_d    = acqIn;
      chSel_d     = nextCh;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
        end
        ACQ: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == (acqEff_q - CNT_W'(1))) begin
            state_d = CONV;
          end
        end
        CONV: begin
          if (periodEnd) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so they are glitch-free enables.
  always_comb begin
    samplePulse_d = startNow;
    acq_d         = (state_d == ACQ);
    convStart_d   = (state_q == ACQ) && (state_d == CONV);
    busy_d        = (state_d != IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      periodEff_q   <= CNT_W'(2);
      acqEff_q      <= CNT_W'(1);
      chSel_q       <= CH_W'(N_CH - 1);
      samplePulse_q <= 1'b0;
      acq_q         <= 1'b0;
      convStart_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      periodEff_q   <= periodEff_d;
      acqEff_q      <= acqEff_d;
      chSel_q       <= chSel_d;
      samplePulse_q <= samplePulse_d;
      acq_q         <= acq_d;
      convStart_q   <= convStart_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.sample_pulse = samplePulse_q;
  assign bus.acq          = acq_q;
  assign bus.conv_start   = convStart_q;
  assign bus.ch_sel       = chSel_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_sar_sample_timer.sv
// Bench for sar_sample_timer: table of programmed configurations plus hand-written
// sequences for reprogramming, enable drop/reassert and asynchronous reset.
module tb_sar_sample_timer;

  typedef struct packed {
    logic       sp;
    logic       acq;
    logic       cs;
    logic       busy;
    logic [1:0] ch;
  } exp_t;

  typedef struct {
    logic [7:0]      div;
    logic [7:0]      acqLen;
    logic [3:0]      mask;
    int              nPer;
    int              expP;
    int              expA;
    logic [0:4][1:0] chSeq;
  } vec_t;

  logic clk_in;
  logic rst_n;
  logic clkEn;
  int   nChecks;
  int   nFails;
  int   cycleIdx;
  string curTag;
  exp_t sb[$];
  vec_t vecs[8];

  sar_sample_timer_if #(.CNT_W(8), .N_CH(4)) bus ();

  sar_sample_timer #(.CNT_W(8), .N_CH(4)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus.slave)
  );

  // Free-running 10-unit clock that can be held still for the no-clock reset check.
  initial begin
    clk_in = 1'b0;
    forever begin
      #5;
      if (clkEn) clk_in = ~clk_in;
    end
  end

  task automatic applyStimulus(input logic en, input logic [7:0] div, input logic [7:0] acqLen,
                               input logic [3:0] mask);
    bus.enable    = en;
    bus.div_ratio = div;
    bus.acq_len   = acqLen;
    bus.ch_mask   = mask;
  endtask

  task automatic pushExp(input logic sp, input logic a, input logic cs, input logic b,
                         input logic [1:0] ch);
    exp_t e;
    e.sp = sp; e.acq = a; e.cs = cs; e.busy = b; e.ch = ch;
    sb.push_back(e);
  endtask

  task automatic pushPeriod(input int p, input int a, input logic [1:0] ch);
    for (int t = 0; t < p; t++) begin
      pushExp(t == 0, t < a, t == a, 1'b1, ch);
    end
  endtask

  task automatic pushIdle(input int n, input logic [1:0] ch);
    for (int t = 0; t < n; t++) begin
      pushExp(1'b0, 1'b0, 1'b0, 1'b0, ch);
    end
  endtask

  task automatic checkOutput();
    exp_t act;
    exp_t exp;
    act = {bus.sample_pulse, bus.acq, bus.conv_start, bus.busy, bus.ch_sel};
    nChecks++;
    if (sb.size() == 0) begin
      nFails++;
      $display("[TB] FAIL %s cycle %0d: scoreboard empty, got sp/acq/cs/busy/ch=%b", curTag, cycleIdx, act);
    end else begin
      exp = sb.pop_front();
      if (act !== exp) begin
        nFails++;
        $display("[TB] FAIL %s cycle %0d: sp/acq/cs/busy/ch got %b expected %b", curTag, cycleIdx, act, exp);
      end
    end
  endtask

  task automatic checkValue(input string name, input logic [5:0] act, input logic [5:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(negedge clk_in);
      checkOutput();
      cycleIdx++;
    end
  endtask

  task automatic doReset(input string tag);
    @(negedge clk_in);
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'd10, 8'd3, 4'b1111);
    #2;
    rst_n = 1'b1;
    curTag   = tag;
    cycleIdx = 0;
  endtask

  initial begin
    nChecks  = 0;
    nFails   = 0;
    cycleIdx = 0;
    curTag   = "init";
    clkEn    = 1'b0;
    rst_n    = 1'b1;
    applyStimulus(1'b0, 8'd0, 8'd0, 4'b0000);

    // {div, acq, mask, periods, expected P, expected A, expected channel per period}
    vecs[0] = '{8'd10, 8'd3,  4'b1111, 5, 10, 3, {2'd0, 2'd1, 2'd2, 2'd3, 2'd0}};
    vecs[1] = '{8'd10, 8'd3,  4'b1010, 4, 10, 3, {2'd1, 2'd3, 2'd1, 2'd3, 2'd0}};
    vecs[2] = '{8'd1,  8'd0,  4'b1111, 3, 2,  1, {2'd0, 2'd1, 2'd2, 2'd0, 2'd0}};
    vecs[3] = '{8'd10, 8'd20, 4'b0001, 2, 10, 9, {2'd0, 2'd0, 2'd0, 2'd0, 2'd0}};
    vecs[4] = '{8'd0,  8'd0,  4'b1000, 2, 2,  1, {2'd3, 2'd3, 2'd0, 2'd0, 2'd0}};
    vecs[5] = '{8'd5,  8'd4,  4'b0110, 3, 5,  4, {2'd1, 2'd2, 2'd1, 2'd0, 2'd0}};
    vecs[6] = '{8'd7,  8'd7,  4'b0100, 2, 7,  6, {2'd2, 2'd2, 2'd0, 2'd0, 2'd0}};
    vecs[7] = '{8'd3,  8'd1,  4'b1001, 3, 3,  1, {2'd0, 2'd3, 2'd0, 2'd0, 2'd0}};

    #3;
    rst_n = 1'b0;
    #1;
    checkValue("reset with clock stopped",
               {bus.sample_pulse, bus.acq, bus.conv_start, bus.busy, bus.ch_sel}, 6'b0000_11);
    clkEn = 1'b1;

    for (int v = 0; v < 8; v++) begin
      doReset($sformatf("vector%0d", v));
      applyStimulus(1'b1, vecs[v].div, vecs[v].acqLen, vecs[v].mask);
      for (int p = 0; p < vecs[v].nPer; p++) begin
        pushPeriod(vecs[v].expP, vecs[v].expA, vecs[v].chSeq[p]);
      end
      pushIdle(4, vecs[v].chSeq[vecs[v].nPer - 1]);
      runCycles(vecs[v].expP * (vecs[v].nPer - 1));
      runCycles(1);
      bus.enable = 1'b0;
      runCycles(vecs[v].expP - 1 + 4);
    end

    // Mask change mid-period only takes effect at the next period start.
    doReset("maskChange");
    applyStimulus(1'b1, 8'd10, 8'd3, 4'b1010);
    pushPeriod(10, 3, 2'd1);
    runCycles(4);
    bus.ch_mask = 4'b0100;
    pushPeriod(10, 3, 2'd2);
    runCycles(7);
    bus.enable = 1'b0;
    pushIdle(3, 2'd2);
    runCycles(12);

    // Period reprogramming, enable glitch inside a period, then a final drop at offset 4.
    doReset("reprogram");
    applyStimulus(1'b1, 8'd10, 8'd3, 4'b1111);
    pushPeriod(10, 3, 2'd0);
    runCycles(3);
    bus.div_ratio = 8'd5;
    pushPeriod(5, 3, 2'd1);
    runCycles(7);
    runCycles(2);
    bus.enable = 1'b0;
    runCycles(1);
    bus.enable    = 1'b1;
    bus.div_ratio = 8'd10;
    pushPeriod(10, 3, 2'd2);
    runCycles(2);
    runCycles(5);
    bus.enable = 1'b0;
    pushIdle(5, 2'd2);
    runCycles(10);

    // Asynchronous reset in the middle of ACQ, then an empty mask keeps the block idle.
    doReset("asyncReset");
    applyStimulus(1'b1, 8'd10, 8'd3, 4'b1111);
    pushExp(1'b1, 1'b1, 1'b0, 1'b1, 2'd0);
    pushExp(1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    runCycles(2);
    #2;
    rst_n = 1'b0;
    #1;
    checkValue("reset mid-ACQ between edges",
               {bus.sample_pulse, bus.acq, bus.conv_start, bus.busy, bus.ch_sel}, 6'b0000_11);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'd10, 8'd3, 4'b0000);
    curTag = "emptyMask";
    pushIdle(50, 2'd3);
    runCycles(50);

    checkValue("scoreboard drained", 6'(sb.size()), 6'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
